serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//   Bit-serial WIDTH-bit adder built around a 3-input / 2-output full-adder cell (sum, carry).
//   Sits directly upstream of that cell: each cycle it presents one LSB-first bit pair plus a
//   registered carry, then captures the cell's sum/carry back into a shift register.
//   Start/done handshake toward the host; result is held until the next start.
// PARAMETERS
//   WIDTH   8   operand and result width in bits; legal range >= 1
// PORTS
//   clk      in   1      single clock; all state updates on rising edge
//   rst      in   1      synchronous, active-high reset
//   start    in   1      request; sampled only in IDLE or DONE
//   a_in     in   WIDTH  operand A; sampled on the edge that accepts start
//   b_in     in   WIDTH  operand B; sampled on the edge that accepts start
//   busy     out  1      high while in SHIFT
//   done     out  1      high for exactly the single DONE cycle
//   sum      out  WIDTH  result A+B mod 2^WIDTH; valid from DONE until the next accepted start
//   cout     out  1      carry out of bit WIDTH-1; valid with sum
// BEHAVIOUR
//   Reset (rst high at an edge): state=IDLE; busy=0, done=0, sum=0, cout=0; carry reg=0; bit count=0.
//     rst takes priority over every other input, including mid-SHIFT: the operation is abandoned.
//   FSM states: IDLE, SHIFT, DONE.
//     IDLE -> SHIFT when start=1. Load shA=a_in, shB=b_in, carry=0, cnt=0.
//     SHIFT: each edge runs the cell with (shA[0], shB[0], carry).
//       - carry <= cell carry.
//       - Shift the cell sum into result MSB; shift right shA, shB and the result.
//       - cnt <= cnt+1.
//       - After WIDTH SHIFT edges (cnt==WIDTH-1 at the edge), go to DONE.
//     DONE -> SHIFT if start=1 (back-to-back accepted; operands reloaded). Otherwise DONE -> IDLE.
//   Latency: start accepted at edge k; done=1 in the cycle following edge k+WIDTH.
//   start during SHIFT is ignored; no queuing; operands are not re-sampled.
//   sum/cout are driven from result/carry registers, which update only in SHIFT.
//     Outside SHIFT they hold the last completed result.
//     During SHIFT, sum/cout are don't-care; hosts must qualify them with done or !busy.
//   Arithmetic: {cout,sum} = a_in + b_in, WIDTH+1 bits, unsigned. No carry-in port.
//   Counter width: $clog2(WIDTH+1). WIDTH=1 completes in one SHIFT edge.
//   busy and done are never high together. Both are pure decodes of the state register.
// STRUCTURE
//   Shared package: state encoding constants (ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2).
//     ST_DONE is used by the sibling serial blocks.
//   One sub-module: fa_bit (a,b,c -> s,co), behavioural, instantiated once.
//     It is interchangeable with the team's switch-level full-adder cell for gate-delay runs.
//   This module holds the FSM, bit counter, operand/result shift registers and the carry flop.
// TESTING (WIDTH=8 unless stated)
//   1. a=0x5A, b=0x3C, start 1 cycle -> busy 8 cycles; done pulse 8 cycles after accept;
//      sum=0x96, cout=0.
//   2. a=0xFF, b=0x01 -> sum=0x00, cout=1.
//      Then a=0xFF, b=0xFF -> sum=0xFE, cout=1.
//   3. start held high during SHIFT, a_in/b_in changed -> result unaffected.
//      Start is re-accepted only in DONE (back-to-back: done for 1 cycle, then busy again).
//   4. rst asserted at SHIFT cycle 4 -> next cycle busy=0, done=0, sum=0, cout=0;
//      a new start then completes correctly.
//   5. Random 1000 operand pairs, random start gaps -> {cout,sum} == a+b at every done;
//      busy&done never both 1.
//   6. WIDTH=1: a=1, b=1 -> done one cycle after accept edge+1; sum=0, cout=1.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
//   state_e : FSM state encoding shared with the sibling serial blocks
//             (ST_DONE is decoded by some of them).
//   cnt_width() : width of a bit counter that must reach w.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_bit.sv
// One-bit full-adder cell, behavioural model.
// Pin-compatible with the switch-level full-adder cell so either can be
// dropped in under serial_adder_ctrl.
//   a, b, c : input bits (c is carry in)
//   s       : sum bit
//   co      : carry out
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit unsigned adder controller.
// Feeds one LSB-first operand bit pair plus the registered carry into a
// single full-adder cell each cycle and shifts the cell sum into a result
// register. Start/done handshake toward the host; result held until the
// next accepted start.
//   clk   : clock, all state on rising edge
//   rst   : synchronous active-high reset, overrides everything
//   start : request, sampled only in IDLE or DONE
//   a_in  : operand A, sampled on the accepting edge
//   b_in  : operand B, sampled on the accepting edge
//   busy  : high while in SHIFT
//   done  : high for the single DONE cycle
//   sum   : A+B mod 2^WIDTH, valid from DONE until next accepted start
//   cout  : carry out of bit WIDTH-1, valid with sum
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | waiting for start, last result held
// ST_SHIFT | one bit per edge through the cell, WIDTH edges total
// ST_DONE  | one-cycle completion strobe, start re-accepted here
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned    CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] sha_q, shb_q, res_q;
    logic [WIDTH-1:0] sha_d, shb_d, res_d;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             cell_s, cell_co;
    logic [WIDTH:0]   res_ext;

    fa_bit u_fa (
        .a  (sha_q[0]),
        .b  (shb_q[0]),
        .c  (carry_q),
        .s  (cell_s),
        .co (cell_co)
    );

    // Concatenate-then-slice keeps the result shift legal for WIDTH=1.
    assign res_ext = {cell_s, res_q};
    assign res_d   = res_ext[WIDTH:1];
    assign sha_d   = sha_q >> 1;
    assign shb_d   = shb_q >> 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sha_q   <= '0;
            shb_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q <= ST_SHIFT;
                        sha_q   <= a_in;
                        shb_q   <= b_in;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    carry_q <= cell_co;
                    res_q   <= res_d;
                    sha_q   <= sha_d;
                    shb_q   <= shb_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state_q == ST_SHIFT);
    assign done = (state_q == ST_DONE);
    assign sum  = res_q;
    assign cout = carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [7:0] a_in, b_in, sum;
    logic       busy, done, cout;

    logic       start1;
    logic [0:0] a1, b1, sum1;
    logic       busy1, done1, cout1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a_in  (a1),
        .b_in  (b1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Issue one op from IDLE/DONE; returns at the negedge of the DONE cycle.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [8:0] exp, input string tag);
        int nb;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy && !done) nb++;
            @(negedge clk);
        end
        check_val({tag, "_busy_cycles"}, nb, 8);
        check_val({tag, "_done"}, {busy, done}, 2'b01);
        check_val({tag, "_result"}, {cout, sum}, exp);
    endtask

    initial begin
        int nb;
        int cyc;
        int excl_viol;
        logic [7:0] ra, rb;

        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;
        @(negedge clk);
        @(negedge clk);
        check_val("reset_w8", {busy, done, cout, sum}, 11'h000);
        check_val("reset_w1", {busy1, done1, cout1, sum1}, 4'h0);
        rst = 1'b0;

        // 1 and 2
        run_op(8'h5A, 8'h3C, 9'h096, "t1");
        @(negedge clk);
        check_val("t1_idle_after", {busy, done, cout, sum}, {2'b00, 9'h096});
        run_op(8'hFF, 8'h01, 9'h100, "t2a");
        run_op(8'hFF, 8'hFF, 9'h1FE, "t2b");

        // 3: start held through SHIFT, operands changed after accept
        @(negedge clk);
        a_in = 8'h12; b_in = 8'h34; start = 1'b1;
        @(negedge clk);
        a_in = 8'hFF; b_in = 8'hFF;
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy && !done) nb++;
            @(negedge clk);
        end
        check_val("t3_busy_cycles", nb, 8);
        check_val("t3_done", {busy, done}, 2'b01);
        check_val("t3_result", {cout, sum}, 9'h046);
        @(negedge clk);
        check_val("t3_reaccept", {busy, done}, 2'b10);
        start = 1'b0;
        for (int i = 0; i < 8; i++) @(negedge clk);
        check_val("t3b_done", {busy, done}, 2'b01);
        check_val("t3b_result", {cout, sum}, 9'h1FE);

        // 4: reset in SHIFT cycle 4
        @(negedge clk);
        a_in = 8'h11; b_in = 8'h22; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_val("t4_busy_c4", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_val("t4_after_rst", {busy, done, cout, sum}, 11'h000);
        rst = 1'b0;
        run_op(8'h0F, 8'h01, 9'h010, "t4_new");

        // 5: random operands, random gaps (gap 0 exercises DONE->SHIFT)
        excl_viol = 0;
        for (int n = 0; n < 1000; n++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                if (busy && done) excl_viol++;
            end
            ra = 8'($urandom);
            rb = 8'($urandom);
            a_in = ra; b_in = rb; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc = 0;
            while (!done && cyc < 12) begin
                if (busy && done) excl_viol++;
                @(negedge clk);
                cyc++;
            end
            if (busy && done) excl_viol++;
            if (done) check_val("t5_result", {cout, sum}, {1'b0, ra} + {1'b0, rb});
            else      check_val("t5_timeout", 0, 1);
        end
        check_val("t5_busy_done_excl", excl_viol, 0);

        // 6: WIDTH=1
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check_val("t6_busy", {busy1, done1}, 2'b10);
        @(negedge clk);
        check_val("t6_done", {busy1, done1}, 2'b01);
        check_val("t6_result", {cout1, sum1}, 2'b10);
        @(negedge clk);
        check_val("t6_idle", {busy1, done1, cout1, sum1}, 4'b0010);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
